// File: rtl/plic_pkg.sv
// Shared address map and types for the platform-level interrupt controller.
package plic_pkg;

    localparam logic [23:0] PLIC_PRIO_BASE = 24'h000000;
    localparam logic [23:0] PLIC_PEND      = 24'h001000;
    localparam logic [23:0] PLIC_EN        = 24'h002000;
    localparam logic [23:0] PLIC_THR       = 24'h200000;
    localparam logic [23:0] PLIC_CLAIM     = 24'h200004;

    localparam int PRIO_W = 3;
    localparam int ID_W   = 5;

    typedef logic [PRIO_W-1:0] prio_t;
    typedef logic [ID_W-1:0]   id_t;

endpackage

// File: rtl/plic_arbiter.sv
// Combinational selector: highest-priority candidate wins, ties go to the lowest ID.
module plic_arbiter
    import plic_pkg::*;
#(
    parameter int i_cnt = 1
) (
    input  prio_t [i_cnt:1] prio,
    input  logic  [i_cnt:1] candidate,
    output id_t             winner,
    output logic            valid
);

    prio_t best;

    // Upward scan with strict greater-than keeps the lowest ID on equal priority,
    // and a priority of 0 can never beat the initial best of 0.
    always_comb begin
        best   = '0;
        winner = '0;
        for (int k = 1; k <= i_cnt; k++) begin
            if (candidate[k] && (prio[k] > best)) begin
                best   = prio[k];
                winner = id_t'(k);
            end
        end
        valid = (winner != '0);
    end

endmodule

// File: rtl/plic_controller.sv
// PLIC top: register file, level gateway, claim/complete and acknowledge logic
// sitting on the core data bus.
module plic_controller
    import plic_pkg::*;
#(
    parameter int i_cnt = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [3:0]       we_i,
    input  logic [23:0]      addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    input  logic [i_cnt:1]   irq_i,
    input  logic             iack_i,
    output logic [i_cnt:1]   iack_o,
    output logic             irq_o
);

    prio_t [i_cnt:1] prio;
    logic  [i_cnt:1] enable;
    logic  [i_cnt:1] pending;
    logic  [i_cnt:1] in_service;
    prio_t           threshold;
    logic            iack_q;

    logic  [i_cnt:1] candidate;
    id_t             winner;
    logic            winner_valid;
    logic  [i_cnt:1] winner_onehot;

    logic            rd_en;
    logic            wr_en;
    logic  [23:0]    word_addr;
    logic  [9:0]     prio_idx;
    logic            prio_sel;
    logic            is_pend;
    logic            is_en;
    logic            is_thr;
    logic            is_claim;
    logic            claim;
    logic            complete;
    logic            iack_edge;
    logic  [i_cnt:1] claim_clr;
    logic  [i_cnt:1] complete_clr;
    logic  [i_cnt:1] enable_next;
    logic  [31:0]    rd_data;
    logic            unused_addr;

    assign unused_addr = ^addr_i[1:0];

    assign rd_en     = en_i && (we_i == 4'b0000);
    assign wr_en     = en_i && (we_i != 4'b0000);
    assign word_addr = {addr_i[23:2], 2'b00};
    assign prio_idx  = addr_i[11:2];
    assign prio_sel  = (addr_i[23:12] == PLIC_PRIO_BASE[23:12]);
    assign is_pend   = (word_addr == PLIC_PEND);
    assign is_en     = (word_addr == PLIC_EN);
    assign is_thr    = (word_addr == PLIC_THR);
    assign is_claim  = (word_addr == PLIC_CLAIM);

    assign claim     = rd_en && is_claim && winner_valid;
    assign complete  = wr_en && is_claim && (data_i != 32'd0) && (data_i <= 32'(i_cnt));
    assign iack_edge = iack_i && !iack_q;

    always_comb begin
        for (int k = 1; k <= i_cnt; k++) begin
            candidate[k]     = pending[k] && enable[k] && (prio[k] > threshold);
            winner_onehot[k] = (winner == id_t'(k));
            claim_clr[k]     = claim && winner_onehot[k];
            complete_clr[k]  = complete && (data_i == 32'(k));
            enable_next[k]   = we_i[k / 8] ? data_i[k] : enable[k];
        end
    end

    plic_arbiter #(
        .i_cnt     (i_cnt)
    ) u_arbiter (
        .prio      (prio),
        .candidate (candidate),
        .winner    (winner),
        .valid     (winner_valid)
    );

    // Read mux; a claim read returns the winner seen in the same cycle it is taken.
    always_comb begin
        rd_data = '0;
        if (prio_sel) begin
            for (int k = 1; k <= i_cnt; k++) begin
                if (prio_idx == 10'(k)) begin
                    rd_data = 32'(prio[k]);
                end
            end
        end else if (is_pend) begin
            rd_data = 32'({pending, 1'b0});
        end else if (is_en) begin
            rd_data = 32'({enable, 1'b0});
        end else if (is_thr) begin
            rd_data = 32'(threshold);
        end else if (is_claim) begin
            rd_data = 32'(winner);
        end
    end

    // Gateway uses the pre-edge in_service, so a source completed this cycle
    // only re-pends on the following edge; a claim always beats a new request.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio       <= '0;
            enable     <= '0;
            pending    <= '0;
            in_service <= '0;
            threshold  <= '0;
            iack_q     <= 1'b0;
            data_o     <= '0;
            iack_o     <= '0;
            irq_o      <= 1'b0;
        end else begin
            iack_q     <= iack_i;
            irq_o      <= winner_valid;
            pending    <= (pending | (irq_i & ~in_service)) & ~claim_clr;
            in_service <= (in_service | claim_clr) & ~complete_clr;
            iack_o     <= (claim || iack_edge) ? winner_onehot : '0;
            if (rd_en) begin
                data_o <= rd_data;
            end
            if (wr_en && is_en) begin
                enable <= enable_next;
            end
            if (wr_en && is_thr && we_i[0]) begin
                threshold <= data_i[PRIO_W-1:0];
            end
            for (int k = 1; k <= i_cnt; k++) begin
                if (wr_en && prio_sel && (prio_idx == 10'(k)) && we_i[0]) begin
                    prio[k] <= data_i[PRIO_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_plic_controller.sv
// Randomized bench for plic_controller with a register-map level reference model
// and a per-cycle compare process, plus directed scenarios pinned to literal values.
module tb_plic_controller;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_i;
    logic [3:0]  we_i;
    logic [23:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [N:1]  irq_i;
    logic        iack_i;
    logic [N:1]  iack_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    logic [N:1] cur_irq = '0;
    logic       cur_ack = 1'b0;

    int   m_prio [1:N];
    bit   m_en   [1:N];
    bit   m_pend [1:N];
    bit   m_insv [1:N];
    int   m_thr;
    bit   m_prev_ack;

    logic [31:0] exp_data;
    logic        exp_irq;
    logic [N:1]  exp_iack;

    plic_controller #(
        .i_cnt  (N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en_i   (en_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .irq_i  (irq_i),
        .iack_i (iack_i),
        .iack_o (iack_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Winner by the rule itself: search priorities from highest down, first ID wins.
    function automatic int modelWinner();
        for (int p = 7; p > m_thr; p--) begin
            for (int id = 1; id <= N; id++) begin
                if (m_pend[id] && m_en[id] && (m_prio[id] == p)) return id;
            end
        end
        return 0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [23:0] addr);
        int word;
        logic [31:0] v;
        word = int'(addr) & ~3;
        v = '0;
        if (word < 'h1000) begin
            if (word / 4 >= 1 && word / 4 <= N) v = 32'(m_prio[word / 4]);
        end else if (word == 'h1000) begin
            for (int id = 1; id <= N; id++) v[id] = m_pend[id];
        end else if (word == 'h2000) begin
            for (int id = 1; id <= N; id++) v[id] = m_en[id];
        end else if (word == 'h200000) begin
            v = 32'(m_thr);
        end else if (word == 'h200004) begin
            v = 32'(modelWinner());
        end
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] we,
                                 input logic [23:0] addr, input logic [31:0] data);
        int          w;
        int          word;
        bit          rd;
        bit          wr;
        bit          is_claim_rd;
        logic [31:0] rv;
        logic [N:1]  irq;
        logic        ack;
        reset  = rst;
        en_i   = en;
        we_i   = we;
        addr_i = addr;
        data_i = data;
        irq    = cur_irq;
        ack    = cur_ack;
        irq_i  = irq;
        iack_i = ack;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int id = 1; id <= N; id++) begin
                m_prio[id] = 0; m_en[id] = 0; m_pend[id] = 0; m_insv[id] = 0;
            end
            m_thr      = 0;
            m_prev_ack = 0;
            exp_data   = '0;
            exp_irq    = 1'b0;
            exp_iack   = '0;
        end else begin
            w           = modelWinner();
            rv          = modelRead(addr);
            word        = int'(addr) & ~3;
            rd          = en && (we == 4'b0000);
            wr          = en && (we != 4'b0000);
            is_claim_rd = rd && (word == 'h200004);
            exp_irq     = (w != 0);
            exp_iack    = '0;
            if (w != 0 && (is_claim_rd || (ack && !m_prev_ack))) exp_iack[w] = 1'b1;
            if (rd) exp_data = rv;
            for (int id = 1; id <= N; id++) begin
                bit claimed;
                bit completed;
                claimed    = is_claim_rd && (id == w);
                completed  = wr && (word == 'h200004) && (data == 32'(id));
                m_pend[id] = (m_pend[id] || (irq[id] && !m_insv[id])) && !claimed;
                m_insv[id] = (m_insv[id] || claimed) && !completed;
            end
            if (wr && word < 'h1000 && word / 4 >= 1 && word / 4 <= N && we[0])
                m_prio[word / 4] = int'(data[2:0]);
            if (wr && word == 'h2000)
                for (int id = 1; id <= N; id++) if (we[id / 8]) m_en[id] = data[id];
            if (wr && word == 'h200000 && we[0]) m_thr = int'(data[2:0]);
            m_prev_ack = ack;
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [23:0] addr, input logic [31:0] data, input logic [3:0] we);
        applyStimulus(1'b0, 1'b1, we, addr, data);
    endtask

    task automatic rd(input logic [23:0] addr);
        applyStimulus(1'b0, 1'b1, 4'b0000, addr, 32'd0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 4'b0000, 24'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            checkOutput("data_o", data_o, exp_data);
            checkOutput("irq_o", 32'(irq_o), 32'(exp_irq));
            checkOutput("iack_o", 32'(iack_o), 32'(exp_iack));
        end
    end

    initial begin
        logic [23:0] rd_addrs [8];
        logic [23:0] a;
        int          op;
        rd_addrs = '{24'h000004, 24'h000010, 24'h000014, 24'h001000,
                     24'h002000, 24'h200000, 24'h200004, 24'h003000};

        applyStimulus(1'b1, 1'b0, 4'b0000, 24'd0, 32'd0);
        applyStimulus(1'b1, 1'b1, 4'b1111, 24'h002000, 32'hFFFF_FFFF);
        cmp_on = 1'b1;
        checkOutput("reset data_o", data_o, 32'd0);
        checkOutput("reset irq_o", 32'(irq_o), 32'd0);
        checkOutput("reset iack_o", 32'(iack_o), 32'd0);
        rd(24'h002000);
        checkOutput("reset enable", data_o, 32'd0);

        // Single source path
        wr(24'h000004, 32'd3, 4'b1111);
        wr(24'h002000, 32'h2, 4'b1111);
        wr(24'h200000, 32'd0, 4'b1111);
        cur_irq = 4'b0001;
        idle();
        idle();
        checkOutput("single irq_o", 32'(irq_o), 32'd1);
        rd(24'h200004);
        checkOutput("single claim id", data_o, 32'd1);
        checkOutput("single iack_o", 32'(iack_o), 32'h1);
        cur_irq = 4'b0000;
        idle();
        checkOutput("single iack end", 32'(iack_o), 32'd0);
        checkOutput("single irq drop", 32'(irq_o), 32'd0);
        wr(24'h200004, 32'd1, 4'b1111);

        // Priority order with ties
        wr(24'h000004, 32'd2, 4'b1111);
        wr(24'h000008, 32'd5, 4'b1111);
        wr(24'h00000C, 32'd5, 4'b1111);
        wr(24'h000010, 32'd1, 4'b1111);
        wr(24'h002000, 32'h1E, 4'b1111);
        cur_irq = 4'b1111;
        idle();
        cur_irq = 4'b0000;
        idle();
        rd(24'h200004);
        checkOutput("prio claim 2", data_o, 32'd2);
        checkOutput("prio iack 2", 32'(iack_o), 32'h2);
        wr(24'h200004, 32'd2, 4'b1111);
        rd(24'h200004);
        checkOutput("prio claim 3", data_o, 32'd3);
        wr(24'h200004, 32'd3, 4'b1111);
        rd(24'h200004);
        checkOutput("prio claim 1", data_o, 32'd1);
        wr(24'h200004, 32'd1, 4'b1111);
        rd(24'h200004);
        checkOutput("prio claim 4", data_o, 32'd4);
        wr(24'h200004, 32'd4, 4'b1111);
        rd(24'h200004);
        checkOutput("prio claim 0", data_o, 32'd0);
        checkOutput("prio iack none", 32'(iack_o), 32'd0);

        // Threshold masking
        wr(24'h200000, 32'd5, 4'b1111);
        cur_irq = 4'b0010;
        idle();
        cur_irq = 4'b0000;
        idle();
        idle();
        checkOutput("thr masked irq_o", 32'(irq_o), 32'd0);
        wr(24'h200000, 32'd4, 4'b1111);
        idle();
        checkOutput("thr open irq_o", 32'(irq_o), 32'd1);
        rd(24'h200004);
        checkOutput("thr claim", data_o, 32'd2);
        wr(24'h200004, 32'd2, 4'b1111);

        // Byte lanes and unmapped / ID 0 priority slots
        wr(24'h002000, 32'hFFFF_FFFF, 4'b0001);
        rd(24'h002000);
        checkOutput("byte lane enable", data_o, 32'h1E);
        applyStimulus(1'b0, 1'b1, 4'b0000, 24'h000010, 32'd0);
        rd(24'h000010);
        checkOutput("we0 no write", data_o, 32'd1);
        wr(24'h000000, 32'd7, 4'b1111);
        rd(24'h000000);
        checkOutput("prio id0", data_o, 32'd0);
        rd(24'h000014);
        checkOutput("prio unmapped", data_o, 32'd0);

        // In-service masking, re-pend after complete, iack_i edge pulse
        wr(24'h200000, 32'd0, 4'b1111);
        cur_irq = 4'b0001;
        idle();
        rd(24'h200004);
        checkOutput("insv claim", data_o, 32'd1);
        idle();
        rd(24'h001000);
        checkOutput("insv pending", data_o, 32'd0);
        wr(24'h200004, 32'd1, 4'b1111);
        idle();
        rd(24'h001000);
        checkOutput("repend pending", data_o, 32'h2);
        checkOutput("repend irq_o", 32'(irq_o), 32'd1);
        cur_irq = 4'b0000;
        cur_ack = 1'b1;
        idle();
        checkOutput("iack pulse", 32'(iack_o), 32'h1);
        idle();
        checkOutput("iack single", 32'(iack_o), 32'd0);
        cur_ack = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) cur_irq = 4'($urandom);
            cur_ack = ($urandom_range(0, 4) == 0);
            op = int'($urandom_range(0, 11));
            a  = {rd_addrs[$urandom_range(0, 7)][23:2], 2'($urandom)};
            case (op)
                0, 1: rd(a);
                2:    rd(24'h200004);
                3:    wr(24'(4 * $urandom_range(0, 5)), $urandom, 4'($urandom_range(1, 15)));
                4:    wr(24'h002000, $urandom, 4'($urandom_range(1, 15)));
                5:    wr(24'h200000, 32'($urandom_range(0, 7)), 4'($urandom_range(1, 15)));
                6, 7: wr(24'h200004, 32'($urandom_range(0, 6)) | ($urandom_range(0, 7) == 0 ? 32'h100 : 32'h0),
                         4'($urandom_range(1, 15)));
                8:    wr(a, $urandom, 4'($urandom_range(1, 15)));
                9:    if ($urandom_range(0, 40) == 0)
                          applyStimulus(1'b1, 1'b1, 4'b1111, 24'h002000, 32'hFFFF_FFFF);
                      else
                          idle();
                default: idle();
            endcase
        end

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
